arm7tdmi_cp_handshake: RTL
==========================

# arm7tdmi_cp_handshake

Coprocessor handshake controller sitting directly downstream of the decoder's coprocessor-op classification (`cp_op_t`). It accepts one decoded coprocessor instruction at a time and drives the external coprocessor strobe. It resolves absent and busy responses and sequences the data phase: MCR write, MRC read, or an LDC/STC word burst. It then reports completion or an undefined-instruction trap to the core control.

## Interface
Parameters:
- `BUSY_TIMEOUT`, 1024: busy-wait cycle limit; only used with the timeout feature.
- `MAX_XFER`, 16: maximum LDC/STC words per instruction.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: decoded coprocessor instruction presented.
- `issue_ready` out 1: block idle and able to accept.
- `issue_op` in 3: `cp_op_t` encoding (CDP 000, LDC 001, STC 010, MRC 100, MCR 110).
- `issue_cpnum` in 4: coprocessor number.
- `issue_len` in 5: LDC/STC word count; 0 is treated as 1; values above `MAX_XFER` are clamped.
- `issue_wdata` in 32: ARM register value for MCR.
- `cpi` out 1: coprocessor instruction strobe.
- `cp_num` out 4: registered coprocessor number.
- `cp_op` out 3: registered op.
- `cp_absent` in 1: no coprocessor claims the instruction.
- `cp_busy` in 1: coprocessor busy-wait request.
- `cp_wdata` out 32: MCR data to coprocessor.
- `cp_wvalid` out 1: MCR data strobe, one cycle.
- `cp_rdata` in 32: MRC data from coprocessor.
- `cp_rvalid` in 1: MRC data valid.
- `xfer_req` out 1: LDC/STC word request to the memory side.
- `xfer_last` out 1: current request is the final word.
- `xfer_ack` in 1: word transferred.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: MRC data; valid with `done`, held until the next MRC.
- `undef` out 1: one-cycle undefined-instruction pulse.
- `timeout` out 1: one-cycle busy-timeout pulse.

## Operation
- States: IDLE, ISSUE, BUSY, MCR_W, MRC_R, XFER, FIN.
- IDLE:
  - `issue_ready`=1.
  - On `issue_valid`, latch op, cpnum, len, and wdata.
  - A reserved op encoding (011/101/111) pulses `undef` next cycle, does not assert `cpi`, and stays in IDLE.
  - A valid op goes to ISSUE.
- ISSUE:
  - `cpi`=1.
  - `cp_absent`=1 → `undef` pulse, then IDLE (absent takes priority over busy).
  - Else `cp_busy`=1 → BUSY.
  - Else dispatch: CDP→FIN, MCR→MCR_W, MRC→MRC_R, LDC/STC→XFER.
- BUSY:
  - `cpi` held at 1; cycle counter increments.
  - When `cp_busy` drops, dispatch as in ISSUE.
  - `cp_absent` in BUSY → `undef`, then IDLE.
- MCR_W: `cp_wvalid`=1 and `cp_wdata`=latched data for exactly one cycle → FIN.
- MRC_R: wait indefinitely for `cp_rvalid`; capture `cp_rdata` into `result` → FIN.
- XFER:
  - `xfer_req`=1 until the final ack.
  - A word counter increments on each `xfer_ack`.
  - `xfer_last`=1 when counter = len−1.
  - Ack on the last word → FIN.
- FIN: `done`=1 for one cycle → IDLE.
- An instruction completes with exactly one of `done`, `undef`, or `timeout`.

## Timing
- Reset:
  - State IDLE.
  - `issue_ready`=1 once out of reset.
  - All other outputs 0, including `result`=0 and the counters.
- Reset asserted mid-operation aborts immediately; no completion pulse is emitted.
- Accept-to-`cpi`: 1 cycle. An accept in cycle N gives `cpi` in cycle N+1.
- Minimum latency, accept to `done`:
  - CDP: 3 cycles (N+2 is FIN).
  - MCR: 4 cycles.
  - MRC: 4 cycles if `cp_rvalid` arrives in the first MRC_R cycle.
  - LDC/STC: 3+len cycles with acks every cycle.
- `cp_absent` and `cp_busy` are sampled only while `cpi`=1; they are ignored elsewhere.
- `xfer_ack` while `xfer_req`=0 is ignored.
- `cp_rvalid` outside MRC_R is ignored.
- `issue_valid` is ignored while `issue_ready`=0; back-to-back accepts happen no sooner than the cycle after FIN or the undef pulse.

## Configuration
- `ARM7TDMI_CP_TIMEOUT_EN` defined:
  - BUSY exits when the counter reaches `BUSY_TIMEOUT`.
  - Exit pulses `timeout` for one cycle, deasserts `cpi`, and returns to IDLE.
- Not defined:
  - BUSY waits indefinitely.
  - `timeout` is tied to 0.
  - No counter logic is built.

## Test plan
- Reset check: assert `rst_n`=0 → all outputs 0. Release reset → `issue_ready`=1, `cpi`=0.
- MRC/MCR round trip:
  - MCR cp 15, wdata 0xDEADBEEF, no busy → `cpi` at N+1; `cp_wvalid` with 0xDEADBEEF at N+2; `done` at N+3.
  - MRC with `cp_rvalid`/0x12345678 after 2 wait cycles → `result`=0x12345678 with `done`.
- Absent and reserved op:
  - CDP with `cp_absent`=1 during `cpi` → single `undef` pulse, no `done`.
  - Op 3'b011 → `undef` next cycle, `cpi` never asserted.
- Busy-wait: `cp_busy` high for 5 cycles, then low, for a CDP → `cpi` high 6 cycles; `done` 1 cycle after busy drops.
- Burst:
  - LDC len 4 with `xfer_ack` stalled every other cycle → exactly 4 acks counted; `xfer_last` on the 4th request; `done` follows.
  - len 0 → 1 word.
- Timeout and reset abort:
  - With `ARM7TDMI_CP_TIMEOUT_EN` and `BUSY_TIMEOUT`=8, `cp_busy` held high → `timeout` pulse after 8 busy cycles, `cpi` drops.
  - Assert `rst_n` mid-XFER → IDLE, no `done`.

Source files
------------

// File: rtl/arm7tdmi_cp_handshake_if.sv
// rtl/arm7tdmi_cp_handshake_if.sv - issue, coprocessor and word-transfer signal bundle for the cp handshake
interface arm7tdmi_cp_handshake_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [2:0]  issue_op;
   logic [3:0]  issue_cpnum;
   logic [4:0]  issue_len;
   logic [31:0] issue_wdata;
   logic        cpi;
   logic [3:0]  cp_num;
   logic [2:0]  cp_op;
   logic        cp_absent;
   logic        cp_busy;
   logic [31:0] cp_wdata;
   logic        cp_wvalid;
   logic [31:0] cp_rdata;
   logic        cp_rvalid;
   logic        xfer_req;
   logic        xfer_last;
   logic        xfer_ack;
   logic        done;
   logic [31:0] result;
   logic        undef;
   logic        timeout;

   modport master (
      input  issue_valid, issue_op, issue_cpnum, issue_len, issue_wdata,
      input  cp_absent, cp_busy, cp_rdata, cp_rvalid, xfer_ack,
      output issue_ready, cpi, cp_num, cp_op, cp_wdata, cp_wvalid,
      output xfer_req, xfer_last, done, result, undef, timeout
   );

   modport slave (
      output issue_valid, issue_op, issue_cpnum, issue_len, issue_wdata,
      output cp_absent, cp_busy, cp_rdata, cp_rvalid, xfer_ack,
      input  issue_ready, cpi, cp_num, cp_op, cp_wdata, cp_wvalid,
      input  xfer_req, xfer_last, done, result, undef, timeout
   );
endinterface

// File: rtl/arm7tdmi_cp_handshake.sv
// rtl/arm7tdmi_cp_handshake.sv - coprocessor handshake controller (busy timeout under ARM7TDMI_CP_TIMEOUT_EN)
module arm7tdmi_cp_handshake #(
   parameter int BUSY_TIMEOUT = 1024,
   parameter int MAX_XFER     = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   arm7tdmi_cp_handshake_if.master        bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_BUSY, S_MCR_W, S_MRC_R, S_XFER, S_FIN
   } state_t;

   localparam logic [2:0] OP_CDP  = 3'b000;
   localparam logic [2:0] OP_MRC  = 3'b100;
   localparam logic [2:0] OP_MCR  = 3'b110;
   localparam logic [4:0] MAX_LEN = 5'(MAX_XFER);

   if (MAX_XFER < 1 || MAX_XFER > 31 || BUSY_TIMEOUT < 1) begin : g_bad_param
      $error("arm7tdmi_cp_handshake: parameter out of range");
   end

   state_t      state, state_nxt, dispatch_state;
   logic [2:0]  op_q;
   logic [3:0]  num_q;
   logic [4:0]  len_q, xcnt_q, len_eff;
   logic [31:0] wdata_q, result_q;
   logic        undef_q, timeout_q;
   logic        accept, op_reserved, last_word, busy_expired;

   assign op_reserved = (bus.issue_op == 3'b011) || (bus.issue_op == 3'b101) ||
                        (bus.issue_op == 3'b111);
   assign bus.issue_ready = rst_n && (state == S_IDLE) && !undef_q && !timeout_q;
   assign accept      = bus.issue_ready && bus.issue_valid;
   assign len_eff     = (bus.issue_len == 5'd0)    ? 5'd1    :
                        (bus.issue_len > MAX_LEN)  ? MAX_LEN : bus.issue_len;
   assign last_word   = (state == S_XFER) && (xcnt_q == len_q - 5'd1);

   always_comb begin
      case (op_q)
         OP_CDP:  dispatch_state = S_FIN;
         OP_MCR:  dispatch_state = S_MCR_W;
         OP_MRC:  dispatch_state = S_MRC_R;
         default: dispatch_state = S_XFER;
      endcase
   end

`ifdef ARM7TDMI_CP_TIMEOUT_EN
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   logic [CW-1:0] busy_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                busy_cnt_q <= '0;
      else if (state != S_BUSY)  busy_cnt_q <= '0;
      else                       busy_cnt_q <= busy_cnt_q + 1'b1;
   end

   assign busy_expired = (state == S_BUSY) && (busy_cnt_q == CW'(BUSY_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timeout_q <= 1'b0;
      else        timeout_q <= busy_expired && bus.cp_busy && !bus.cp_absent;
   end
`else
   assign busy_expired = 1'b0;
   assign timeout_q    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // absent beats busy; a busy drop beats an expiring counter in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && !op_reserved) state_nxt = S_ISSUE;
         S_ISSUE, S_BUSY: begin
            if (bus.cp_absent)      state_nxt = S_IDLE;
            else if (!bus.cp_busy)  state_nxt = dispatch_state;
            else if (busy_expired)  state_nxt = S_IDLE;
            else                    state_nxt = S_BUSY;
         end
         S_MCR_W: state_nxt = S_FIN;
         S_MRC_R: if (bus.cp_rvalid) state_nxt = S_FIN;
         S_XFER:  if (bus.xfer_ack && last_word) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cpi       = (state == S_ISSUE) || (state == S_BUSY);
      bus.cp_wvalid = (state == S_MCR_W);
      bus.cp_wdata  = (state == S_MCR_W) ? wdata_q : 32'd0;
      bus.xfer_req  = (state == S_XFER);
      bus.xfer_last = last_word;
      bus.done      = (state == S_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         num_q    <= '0;
         len_q    <= '0;
         wdata_q  <= '0;
         xcnt_q   <= '0;
         result_q <= '0;
         undef_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= bus.issue_op;
            num_q   <= bus.issue_cpnum;
            len_q   <= len_eff;
            wdata_q <= bus.issue_wdata;
            xcnt_q  <= '0;
         end else if (state == S_XFER && bus.xfer_ack) begin
            xcnt_q  <= xcnt_q + 5'd1;
         end
         if (state == S_MRC_R && bus.cp_rvalid) result_q <= bus.cp_rdata;
         undef_q <= (accept && op_reserved) || (bus.cpi && bus.cp_absent);
      end
   end

   assign bus.cp_num  = num_q;
   assign bus.cp_op   = op_q;
   assign bus.result  = result_q;
   assign bus.undef   = undef_q;
   assign bus.timeout = timeout_q;
endmodule
